// File: rtl/regseq_pkg.sv
// Shared state encoding, datapath control codes and sizes for the register-file sequencer.
// Pure definitions; no latency or backpressure of its own.
package regseq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LFLUSH = 2'd2,
    DUMP   = 2'd3
  } state_t;

  localparam logic [4:0] FS_PASS_S  = 5'h00;
  localparam logic [4:0] FS_LOAD    = 5'h01;
  localparam logic [2:0] Y_SEL_ALU  = 3'b010;
  localparam int         NUM_REGS   = 32;
  localparam int         DUMP_PAIRS = 16;

  // T-side register paired with S-side register j during a dump.
  function automatic logic [4:0] t_addr_of(input logic [4:0] j);
    return 5'(DUMP_PAIRS) + j;
  endfunction

endpackage

// File: rtl/regseq_addr_cnt.sv
// 5-bit index counter with clear/enable and terminal-count flag (cnt == n-1, n=0 means 32).
// Counts one step per cycle with en; last is combinational from the held count, no backpressure.
module regseq_addr_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [4:0] n,
  output logic [4:0] cnt,
  output logic       last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 5'd0;
    end else if (clr) begin
      cnt <= 5'd0;
    end else if (en) begin
      cnt <= cnt + 5'd1;
    end
  end

  // n=0 wraps to 31 here, which is exactly the 32-word terminal count.
  assign last = (cnt == (n - 5'd1));

endmodule

// File: rtl/regfile_sequencer.sv
// Loads N words into the register file, or (REGSEQ_DUMP_EN) dumps 16 S/T register pairs.
// All outputs registered; load writes land one cycle after wr_valid&&wr_ready, dump data one cycle after its address.
// Load backpressure via wr_ready, which drops once the N-th word is taken; start pulses are ignored while busy.
module regfile_sequencer
  import regseq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [4:0]  load_cnt,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        dump_start,
  output logic [31:0] rd_s,
  output logic [31:0] rd_t,
  output logic [3:0]  rd_idx,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        D_En,
  output logic [4:0]  D_Addr,
  output logic [31:0] DT,
  output logic        T_Sel,
  output logic [4:0]  FS,
  output logic [2:0]  Y_Sel,
  output logic [4:0]  S_Addr,
  output logic [4:0]  T_Addr,
  input  logic [31:0] ALU_OUT,
  input  logic [31:0] D_OUT
);

  state_t      state_q, state_d;
  logic [4:0]  n_q, n_d;
  logic        wr_ready_d, D_En_d, T_Sel_d, busy_d, done_d;
  logic [4:0]  D_Addr_d, FS_d;
  logic [31:0] DT_d;
  logic        cnt_clr, cnt_en, cnt_last;
  logic [4:0]  cnt, cnt_n;

`ifdef REGSEQ_DUMP_EN
  logic [4:0]  S_Addr_d, T_Addr_d;
  logic [31:0] rd_s_d, rd_t_d;
  logic [3:0]  rd_idx_d;
  logic        rd_valid_d;
`endif

  assign cnt_n = (state_q == DUMP) ? 5'(DUMP_PAIRS) : n_q;

  regseq_addr_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .n     (cnt_n),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wr_ready_d = wr_ready;
    D_En_d     = 1'b0;
    D_Addr_d   = D_Addr;
    DT_d       = DT;
    T_Sel_d    = T_Sel;
    FS_d       = FS;
    busy_d     = busy;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
`ifdef REGSEQ_DUMP_EN
    S_Addr_d   = S_Addr;
    T_Addr_d   = T_Addr;
    rd_s_d     = rd_s;
    rd_t_d     = rd_t;
    rd_idx_d   = rd_idx;
    rd_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (load_start) begin
          state_d    = LOAD;
          n_d        = load_cnt;
          T_Sel_d    = 1'b0;
          FS_d       = FS_LOAD;
          wr_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
`ifdef REGSEQ_DUMP_EN
        else if (dump_start) begin
          state_d  = DUMP;
          busy_d   = 1'b1;
          S_Addr_d = 5'd0;
          T_Addr_d = t_addr_of(5'd0);
        end
`endif
      end
      LOAD: begin
        if (wr_valid && wr_ready) begin
          D_En_d   = 1'b1;
          D_Addr_d = cnt;
          DT_d     = wr_data;
          // Hold the counter on the last word so it never wraps.
          if (cnt_last) begin
            wr_ready_d = 1'b0;
            state_d    = LFLUSH;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      LFLUSH: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        wr_ready_d = 1'b0;
        T_Sel_d    = 1'b1;
        FS_d       = FS_PASS_S;
      end
`ifdef REGSEQ_DUMP_EN
      DUMP: begin
        rd_s_d     = ALU_OUT;
        rd_t_d     = D_OUT;
        rd_idx_d   = cnt[3:0];
        rd_valid_d = 1'b1;
        if (cnt_last) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          S_Addr_d = 5'd0;
          T_Addr_d = t_addr_of(5'd0);
        end else begin
          cnt_en   = 1'b1;
          S_Addr_d = cnt + 5'd1;
          T_Addr_d = t_addr_of(cnt + 5'd1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= 5'd0;
      wr_ready <= 1'b0;
      D_En     <= 1'b0;
      D_Addr   <= 5'd0;
      DT       <= 32'd0;
      T_Sel    <= 1'b1;
      FS       <= FS_PASS_S;
      Y_Sel    <= Y_SEL_ALU;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wr_ready <= wr_ready_d;
      D_En     <= D_En_d;
      D_Addr   <= D_Addr_d;
      DT       <= DT_d;
      T_Sel    <= T_Sel_d;
      FS       <= FS_d;
      Y_Sel    <= Y_SEL_ALU;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef REGSEQ_DUMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      S_Addr   <= 5'd0;
      T_Addr   <= t_addr_of(5'd0);
      rd_s     <= 32'd0;
      rd_t     <= 32'd0;
      rd_idx   <= 4'd0;
      rd_valid <= 1'b0;
    end else begin
      S_Addr   <= S_Addr_d;
      T_Addr   <= T_Addr_d;
      rd_s     <= rd_s_d;
      rd_t     <= rd_t_d;
      rd_idx   <= rd_idx_d;
      rd_valid <= rd_valid_d;
    end
  end
`else
  logic dump_unused;
  assign dump_unused = ^{ALU_OUT, D_OUT, dump_start};
  assign S_Addr   = 5'd0;
  assign T_Addr   = t_addr_of(5'd0);
  assign rd_s     = 32'd0;
  assign rd_t     = 32'd0;
  assign rd_idx   = 4'd0;
  assign rd_valid = 1'b0;
`endif

endmodule
